// File: rtl/busytable_pkg.sv
// Shared definitions for the multi-port busy table.
//   PREG_NUM_DEF / PREG_W_DEF : default physical register count and index width
//   preg_t                    : preg index at default width
//   PREG_ZERO                 : hardwired-ready physical register
package busytable_pkg;

  localparam int unsigned PREG_NUM_DEF = 64;
  localparam int unsigned PREG_W_DEF   = $clog2(PREG_NUM_DEF);

  typedef logic [PREG_W_DEF-1:0] preg_t;

  localparam preg_t PREG_ZERO = '0;

endpackage

// File: rtl/busytable_rdport.sv
// Single busy-table read port: bypasses same-cycle writeback and speculative
// wakeup/cancel events onto the registered busy bit.
//   rd_addr_i        : source preg index
//   busy_i           : registered busy vector
//   wb_en_i/wb_addr_i: writeback strobes and pregs (flattened)
//   spec_wake_*      : speculative wakeup issued this cycle
//   spec_vld_i/addr_i: wakeup issued last cycle, now in its confirm window
//   spec_cancel_i    : cancels the wakeup held in the spec stage
//   rd_busy_o        : 1 = source not ready
//   rd_spec_o        : 1 = source ready only speculatively
module busytable_rdport
  import busytable_pkg::*;
#(
  parameter int unsigned PREG_NUM = PREG_NUM_DEF,
  parameter int unsigned PREG_W   = $clog2(PREG_NUM),
  parameter int unsigned NUM_WB   = 2
) (
  input  logic [PREG_W-1:0]        rd_addr_i,
  input  logic [PREG_NUM-1:0]      busy_i,
  input  logic [NUM_WB-1:0]        wb_en_i,
  input  logic [NUM_WB*PREG_W-1:0] wb_addr_i,
  input  logic                     spec_wake_en_i,
  input  logic [PREG_W-1:0]        spec_wake_addr_i,
  input  logic                     spec_vld_i,
  input  logic [PREG_W-1:0]        spec_addr_i,
  input  logic                     spec_cancel_i,
  output logic                     rd_busy_o,
  output logic                     rd_spec_o
);

  logic wb_hit;
  logic wake_hit;
  logic cancel_hit;
  logic confirm_hit;
  logic is_zero;

  always_comb begin
    wb_hit = 1'b0;
    for (int k = 0; k < int'(NUM_WB); k++) begin
      if (wb_en_i[k] && (wb_addr_i[k*PREG_W +: PREG_W] == rd_addr_i)) begin
        wb_hit = 1'b1;
      end
    end
  end

  assign is_zero     = (rd_addr_i == PREG_W'(PREG_ZERO));
  assign wake_hit    = spec_wake_en_i && (spec_wake_addr_i == rd_addr_i);
  assign cancel_hit  = spec_vld_i && spec_cancel_i && (spec_addr_i == rd_addr_i);
  assign confirm_hit = spec_vld_i && !spec_cancel_i && (spec_addr_i == rd_addr_i);

  // Priority: preg 0, writeback, cancel (re-busy), wakeup, stored bit.
  always_comb begin
    rd_busy_o = busy_i[rd_addr_i];
    rd_spec_o = 1'b0;
    if (is_zero) begin
      rd_busy_o = 1'b0;
    end else if (wb_hit) begin
      rd_busy_o = 1'b0;
    end else if (cancel_hit) begin
      rd_busy_o = 1'b1;
    end else if (wake_hit) begin
      rd_busy_o = 1'b0;
    end
    if (!rd_busy_o && !is_zero && !wb_hit && (wake_hit || confirm_hit)) begin
      rd_spec_o = 1'b1;
    end
  end

endmodule

// File: rtl/busytable_mp.sv
// Multi-port rename busy table with one speculative load-wakeup channel.
//   clock_i/reset_i          : clock, async active-high reset
//   rd_addr_i/rd_busy_o/rd_spec_o : NUM_RD combinational read ports
//   alloc_en_i/alloc_addr_i  : set-busy ports (rename destinations)
//   wb_en_i/wb_addr_i        : clear-busy ports (completed pregs)
//   spec_wake_en_i/addr_i    : speculative load wakeup (clears busy)
//   spec_cancel_i            : re-sets busy for last cycle's wakeup
//   flush_i                  : clears the whole table next cycle
//   busy_cnt_o               : registered number of busy pregs
module busytable_mp
  import busytable_pkg::*;
#(
  parameter int unsigned PREG_NUM  = PREG_NUM_DEF,
  parameter int unsigned PREG_W    = $clog2(PREG_NUM),
  parameter int unsigned NUM_RD    = 4,
  parameter int unsigned NUM_ALLOC = 2,
  parameter int unsigned NUM_WB    = 2
) (
  input  logic                        clock_i,
  input  logic                        reset_i,
  input  logic [NUM_RD*PREG_W-1:0]    rd_addr_i,
  output logic [NUM_RD-1:0]           rd_busy_o,
  output logic [NUM_RD-1:0]           rd_spec_o,
  input  logic [NUM_ALLOC-1:0]        alloc_en_i,
  input  logic [NUM_ALLOC*PREG_W-1:0] alloc_addr_i,
  input  logic [NUM_WB-1:0]           wb_en_i,
  input  logic [NUM_WB*PREG_W-1:0]    wb_addr_i,
  input  logic                        spec_wake_en_i,
  input  logic [PREG_W-1:0]           spec_wake_addr_i,
  input  logic                        spec_cancel_i,
  input  logic                        flush_i,
  output logic [PREG_W:0]             busy_cnt_o
);

  localparam int unsigned CNT_W = PREG_W + 1;

  logic [PREG_NUM-1:0] busy_q, busy_d;
  logic                spec_vld_q, spec_vld_d;
  logic [PREG_W-1:0]   spec_addr_q, spec_addr_d;
  logic [CNT_W-1:0]    busy_cnt_q, busy_cnt_d;

  logic [PREG_NUM-1:0] alloc_hit;
  logic [PREG_NUM-1:0] wb_hit;
  logic [PREG_NUM-1:0] cancel_hit;
  logic [PREG_NUM-1:0] wake_hit;
  logic [CNT_W-1:0]    set_cnt;
  logic [CNT_W-1:0]    clr_cnt;

  // One-hot decode of every write source; duplicates collapse naturally.
  always_comb begin
    alloc_hit  = '0;
    wb_hit     = '0;
    cancel_hit = '0;
    wake_hit   = '0;
    for (int k = 0; k < int'(NUM_ALLOC); k++) begin
      if (alloc_en_i[k]) alloc_hit[alloc_addr_i[k*PREG_W +: PREG_W]] = 1'b1;
    end
    for (int k = 0; k < int'(NUM_WB); k++) begin
      if (wb_en_i[k]) wb_hit[wb_addr_i[k*PREG_W +: PREG_W]] = 1'b1;
    end
    if (spec_vld_q && spec_cancel_i) cancel_hit[spec_addr_q] = 1'b1;
    if (spec_wake_en_i) wake_hit[spec_wake_addr_i] = 1'b1;
  end

  // Per-entry next state: flush > alloc > wb > cancel > wake.
  always_comb begin
    busy_d = busy_q;
    for (int j = 1; j < int'(PREG_NUM); j++) begin
      if (flush_i)            busy_d[j] = 1'b0;
      else if (alloc_hit[j])  busy_d[j] = 1'b1;
      else if (wb_hit[j])     busy_d[j] = 1'b0;
      else if (cancel_hit[j]) busy_d[j] = 1'b1;
      else if (wake_hit[j])   busy_d[j] = 1'b0;
    end
    busy_d[0] = 1'b0;
  end

  // Count only real transitions so the counter tracks popcount exactly.
  always_comb begin
    set_cnt = '0;
    clr_cnt = '0;
    for (int j = 1; j < int'(PREG_NUM); j++) begin
      set_cnt = set_cnt + CNT_W'(busy_d[j] & ~busy_q[j]);
      clr_cnt = clr_cnt + CNT_W'(~busy_d[j] & busy_q[j]);
    end
    busy_cnt_d = flush_i ? '0 : (busy_cnt_q + set_cnt - clr_cnt);
  end

  // Spec stage holds a wakeup for exactly one confirm/cancel cycle.
  always_comb begin
    spec_vld_d  = spec_wake_en_i && !flush_i &&
                  (spec_wake_addr_i != PREG_W'(PREG_ZERO));
    spec_addr_d = spec_wake_en_i ? spec_wake_addr_i : spec_addr_q;
  end

  always_ff @(posedge clock_i or posedge reset_i) begin
    if (reset_i) begin
      busy_q      <= '0;
      spec_vld_q  <= 1'b0;
      spec_addr_q <= '0;
      busy_cnt_q  <= '0;
    end else begin
      busy_q      <= busy_d;
      spec_vld_q  <= spec_vld_d;
      spec_addr_q <= spec_addr_d;
      busy_cnt_q  <= busy_cnt_d;
    end
  end

  assign busy_cnt_o = busy_cnt_q;

  for (genvar i = 0; i < int'(NUM_RD); i++) begin : g_rd
    busytable_rdport #(
      .PREG_NUM (PREG_NUM),
      .PREG_W   (PREG_W),
      .NUM_WB   (NUM_WB)
    ) u_rdport (
      .rd_addr_i        (rd_addr_i[i*PREG_W +: PREG_W]),
      .busy_i           (busy_q),
      .wb_en_i          (wb_en_i),
      .wb_addr_i        (wb_addr_i),
      .spec_wake_en_i   (spec_wake_en_i),
      .spec_wake_addr_i (spec_wake_addr_i),
      .spec_vld_i       (spec_vld_q),
      .spec_addr_i      (spec_addr_q),
      .spec_cancel_i    (spec_cancel_i),
      .rd_busy_o        (rd_busy_o[i]),
      .rd_spec_o        (rd_spec_o[i])
    );
  end

endmodule

// File: tb/tb_busytable_mp.sv
// Directed bench for busytable_mp: expected read-port flags and busy count are
// queued with each stimulus step and compared at the following falling edge.
module tb_busytable_mp;

  logic        clock;
  logic        reset;
  logic [23:0] rd_addr;
  logic [3:0]  rd_busy;
  logic [3:0]  rd_spec;
  logic [1:0]  alloc_en;
  logic [11:0] alloc_addr;
  logic [1:0]  wb_en;
  logic [11:0] wb_addr;
  logic        spec_wake_en;
  logic [5:0]  spec_wake_addr;
  logic        spec_cancel;
  logic        flush;
  logic [6:0]  busy_cnt;

  typedef struct {
    string      tag;
    logic [3:0] busy;
    logic [3:0] spec;
    logic [6:0] cnt;
  } exp_t;

  exp_t sb[$];
  int   n_checks = 0;
  int   n_err    = 0;

  busytable_mp dut (
    .clock_i          (clock),
    .reset_i          (reset),
    .rd_addr_i        (rd_addr),
    .rd_busy_o        (rd_busy),
    .rd_spec_o        (rd_spec),
    .alloc_en_i       (alloc_en),
    .alloc_addr_i     (alloc_addr),
    .wb_en_i          (wb_en),
    .wb_addr_i        (wb_addr),
    .spec_wake_en_i   (spec_wake_en),
    .spec_wake_addr_i (spec_wake_addr),
    .spec_cancel_i    (spec_cancel),
    .flush_i          (flush),
    .busy_cnt_o       (busy_cnt)
  );

  initial clock = 1'b0;
  always #5 clock = ~clock;

  task automatic set_rd(input logic [5:0] a0, input logic [5:0] a1,
                        input logic [5:0] a2, input logic [5:0] a3);
    rd_addr = {a3, a2, a1, a0};
  endtask

  task automatic idle();
    alloc_en       = 2'b00;
    alloc_addr     = '0;
    wb_en          = 2'b00;
    wb_addr        = '0;
    spec_wake_en   = 1'b0;
    spec_wake_addr = '0;
    spec_cancel    = 1'b0;
    flush          = 1'b0;
  endtask

  task automatic check_front();
    exp_t e;
    e = sb.pop_front();
    n_checks++;
    assert (rd_busy === e.busy) else begin
      n_err++;
      $error("FAIL %s rd_busy got=%b exp=%b", e.tag, rd_busy, e.busy);
    end
    n_checks++;
    assert (rd_spec === e.spec) else begin
      n_err++;
      $error("FAIL %s rd_spec got=%b exp=%b", e.tag, rd_spec, e.spec);
    end
    n_checks++;
    assert (busy_cnt === e.cnt) else begin
      n_err++;
      $error("FAIL %s busy_cnt got=%0d exp=%0d", e.tag, busy_cnt, e.cnt);
    end
  endtask

  // Compare at the falling edge, then let the rising edge apply the step.
  task automatic tick();
    @(negedge clock);
    if (sb.size() > 0) check_front();
    @(posedge clock);
    #1;
  endtask

  task automatic step(input string tag, input logic [3:0] b,
                      input logic [3:0] s, input logic [6:0] c);
    exp_t e;
    e.tag  = tag;
    e.busy = b;
    e.spec = s;
    e.cnt  = c;
    sb.push_back(e);
    tick();
  endtask

  initial begin
    idle();
    reset = 1'b1;
    set_rd(6'd1, 6'd5, 6'd9, 6'd63);
    #1;
    step("reset", 4'b0000, 4'b0000, 7'd0);
    reset = 1'b0;
    step("post_reset", 4'b0000, 4'b0000, 7'd0);

    // Allocate 5 and 9; alloc is not bypassed to reads.
    alloc_en = 2'b11; alloc_addr = {6'd9, 6'd5};
    set_rd(6'd5, 6'd9, 6'd1, 6'd63);
    step("alloc_nobypass", 4'b0000, 4'b0000, 7'd0);

    idle();
    wb_en = 2'b01; wb_addr = {6'd0, 6'd5};
    set_rd(6'd5, 6'd9, 6'd1, 6'd0);
    step("wb_bypass", 4'b0010, 4'b0000, 7'd2);

    idle();
    step("after_wb", 4'b0010, 4'b0000, 7'd1);

    // Speculative wakeup on 9, then cancel.
    spec_wake_en = 1'b1; spec_wake_addr = 6'd9;
    set_rd(6'd9, 6'd5, 6'd0, 6'd1);
    step("wake", 4'b0000, 4'b0001, 7'd1);

    idle();
    spec_cancel = 1'b1;
    step("cancel", 4'b0001, 4'b0000, 7'd0);

    idle();
    step("after_cancel", 4'b0001, 4'b0000, 7'd1);

    // Wakeup again, confirmed.
    spec_wake_en = 1'b1; spec_wake_addr = 6'd9;
    step("wake2", 4'b0000, 4'b0001, 7'd1);

    idle();
    step("confirm", 4'b0000, 4'b0001, 7'd0);

    // Cancel with empty spec stage has no effect.
    spec_cancel = 1'b1;
    step("stray_cancel", 4'b0000, 4'b0000, 7'd0);

    idle();
    step("after_stray", 4'b0000, 4'b0000, 7'd0);

    // Alloc and wb on 12 (alloc wins); alloc to preg 0 ignored.
    alloc_en = 2'b11; alloc_addr = {6'd0, 6'd12};
    wb_en = 2'b01; wb_addr = {6'd0, 6'd12};
    set_rd(6'd12, 6'd0, 6'd0, 6'd0);
    step("alloc_wb_same", 4'b0000, 4'b0000, 7'd0);

    idle();
    step("alloc_wins", 4'b0001, 4'b0000, 7'd1);

    // Duplicate alloc on 20 counted once.
    alloc_en = 2'b11; alloc_addr = {6'd20, 6'd20};
    set_rd(6'd12, 6'd20, 6'd0, 6'd0);
    step("dup_alloc", 4'b0001, 4'b0000, 7'd1);

    idle();
    set_rd(6'd20, 6'd12, 6'd0, 6'd0);
    step("after_dup", 4'b0011, 4'b0000, 7'd2);

    // Fill pregs 1..20.
    for (int i = 0; i < 10; i++) begin
      alloc_en   = 2'b11;
      alloc_addr = {6'(2*i + 2), 6'(2*i + 1)};
      tick();
    end
    idle();
    set_rd(6'd1, 6'd13, 6'd20, 6'd21);
    step("filled", 4'b0111, 4'b0000, 7'd20);

    // Flush beats same-cycle alloc; reads see no flush bypass.
    flush = 1'b1;
    alloc_en = 2'b01; alloc_addr = {6'd0, 6'd30};
    wb_en = 2'b01; wb_addr = {6'd0, 6'd3};
    set_rd(6'd1, 6'd30, 6'd3, 6'd21);
    step("flush_cycle", 4'b0001, 4'b0000, 7'd20);

    idle();
    set_rd(6'd1, 6'd30, 6'd20, 6'd12);
    step("after_flush", 4'b0000, 4'b0000, 7'd0);

    // Reset asserted in the cancel cycle of a wakeup on 7.
    alloc_en = 2'b01; alloc_addr = {6'd0, 6'd7};
    set_rd(6'd7, 6'd0, 6'd0, 6'd0);
    step("alloc7", 4'b0000, 4'b0000, 7'd0);

    idle();
    step("busy7", 4'b0001, 4'b0000, 7'd1);

    spec_wake_en = 1'b1; spec_wake_addr = 6'd7;
    step("wake7", 4'b0000, 4'b0001, 7'd1);

    idle();
    spec_cancel = 1'b1;
    reset = 1'b1;
    step("reset_in_cancel", 4'b0000, 4'b0000, 7'd0);

    reset = 1'b0;
    step("cancel_after_reset", 4'b0000, 4'b0000, 7'd0);

    idle();
    step("final", 4'b0000, 4'b0000, 7'd0);

    $display("Result: errors=%0d of %0d checks", n_err, n_checks);
    $finish;
  end

endmodule

// File: doc/busytable_mp.md
Name: busytable_mp

Overview:
- Parametrised successor of the rename-stage busy table. Tracks a busy bit per physical register.
- Adds configurable read, alloc and writeback port counts.
- Adds one speculative load-wakeup channel with next-cycle cancel, a full-flush clear, a hardwired-ready preg 0, and a registered busy-entry counter.
- Sits between rename/free-list and dispatch; issue queues consume busy and spec-ready flags.

Parameters:
- PREG_NUM, 64, number of physical registers (power of 2).
- PREG_W, $clog2(PREG_NUM), preg index width.
- NUM_RD, 4, combinational read ports.
- NUM_ALLOC, 2, allocate (set-busy) ports.
- NUM_WB, 2, writeback (clear-busy) ports.

Ports:
- clock  in  1  single clock, rising edge.
- reset  in  1  asynchronous, active-high reset.
- rd_addr  in  NUM_RD*PREG_W  source preg indices.
- rd_busy  out  NUM_RD  1 = source not ready.
- rd_spec  out  NUM_RD  1 = source ready only speculatively (load wakeup not yet confirmed).
- alloc_en  in  NUM_ALLOC  allocate strobe per port.
- alloc_addr  in  NUM_ALLOC*PREG_W  newly renamed destination pregs.
- wb_en  in  NUM_WB  writeback strobe.
- wb_addr  in  NUM_WB*PREG_W  completed pregs.
- spec_wake_en  in  1  speculative load wakeup.
- spec_wake_addr  in  PREG_W  load destination.
- spec_cancel  in  1  cancels the wakeup issued in the previous cycle.
- flush  in  1  full pipeline flush.
- busy_cnt  out  PREG_W+1  registered count of busy entries.

Behaviour:
- State:
  - busy[PREG_NUM].
  - Spec stage register: spec_vld_q, spec_addr_q.
  - busy_cnt register.
- Reset (async, reset=1): all busy=0, spec_vld_q=0, busy_cnt=0. Outputs follow combinationally (rd_busy=0, rd_spec=0).
- Preg 0: always reads busy=0 and spec=0. All writes to index 0 are ignored and never counted.
- Next-state priority per entry, highest first:
  1. flush
  2. alloc (set)
  3. wb (clear)
  4. spec_cancel on spec_addr_q (set)
  5. spec_wake (clear)
- flush:
  - Next cycle, all busy=0, spec_vld_q=0, busy_cnt=0.
  - flush overrides every same-cycle event, including alloc.
- Spec pipeline:
  - spec_wake_en clears busy[spec_wake_addr] at the edge.
  - Loads spec_vld_q=1, spec_addr_q=addr.
  - The next cycle is the only confirm/cancel window:
    - spec_cancel=1 with spec_vld_q: busy[spec_addr_q] is set again, unless a same-cycle wb/alloc to that addr decides it.
    - spec_cancel=0: the wakeup is confirmed.
  - spec_vld_q is cleared each cycle unless a new spec_wake_en arrives. Back-to-back wakeups are allowed.
  - spec_cancel while spec_vld_q=0 is ignored.
- Read ports (combinational), for each i with a=rd_addr[i]:
  - rd_busy=0 if a==0.
  - Else rd_busy=0 if any wb_en[k] && wb_addr[k]==a.
  - Else rd_busy=1 if spec_vld_q && spec_cancel && spec_addr_q==a.
  - Else rd_busy=0 if spec_wake_en && spec_wake_addr==a.
  - Else rd_busy=busy[a].
  - rd_spec=1 iff rd_busy=0, a!=0, no wb hit, and either:
    - spec_wake_en hits a, or
    - spec_vld_q && !spec_cancel && spec_addr_q==a.
  - Same-cycle alloc is NOT bypassed to reads. Rename resolves intra-group dependencies.
  - flush does not bypass reads.
- Duplicate addresses:
  - Two alloc ports on the same preg, or two wb ports on the same preg: legal, idempotent.
  - Alloc and wb to the same preg in one cycle: alloc wins (busy=1).
- busy_cnt:
  - Equals popcount of busy[1..PREG_NUM-1] after the edge.
  - Maintained incrementally: +set transitions, −clear transitions, counting only actual 0→1 / 1→0 changes with duplicates counted once.
  - Never exceeds PREG_NUM-1.
- Reset asserted mid-operation: immediate clear, including spec stage. First post-reset spec_cancel is ignored.

Decomposition:
- Shared package busytable_pkg:
  - PREG_NUM/PREG_W defaults.
  - preg_t typedef.
  - Constant PREG_ZERO=0.
- One sub-module, busytable_rdport: single read-port bypass/priority mux, instantiated NUM_RD times.
- Next-state vector and popcount-delta logic live in the top module.

Test Plan:
- Reset, then read addrs {1,5,9,63} -> rd_busy=0000, rd_spec=0000, busy_cnt=0.
- alloc_en=11 addr {5,9}; next cycle read 5,9 -> busy=1 each, busy_cnt=2. Same cycle wb_en=01 addr 5 -> rd_busy for 5 =0 bypassed; next cycle busy_cnt=1.
- Speculative wakeup:
  - busy[9]=1, spec_wake_en addr 9 -> same-cycle rd_busy=0, rd_spec=1.
  - Next cycle spec_cancel=1 -> rd_busy=1 that cycle.
  - Following cycle busy[9]=1, busy_cnt unchanged.
  - Repeat without cancel -> rd_spec=1 in the confirm cycle, then rd_spec=0, busy=0.
- alloc and wb both to preg 12 in one cycle -> busy[12]=1. alloc to preg 0 -> rd_busy(0)=0, busy_cnt unchanged.
- Allocate pregs 1..20, then flush together with alloc addr 30 -> next cycle all reads 0, busy_cnt=0.
- Spec wake on 7, then assert reset in the cancel cycle -> after release, busy[7]=0 and spec_cancel has no effect.
